uart_tx_frame_ctrl: RTL
=======================

// Module: uart_tx_frame_ctrl
// PURPOSE
//  Frame controller for the UART transmit path; sits directly upstream of uart_tx_serializer.
//  Accepts a parallel byte with a valid strobe and latches it for the serializer.
//  Sequences start bit, 8 data bits (LSB first, via the serializer), optional parity bit and stop bit.
//  Muxes the result onto the TX line. One bit per clk cycle; the baud enable is external.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame; must equal the serializer DATA_WIDTH (max 15)
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  rst         in   1           synchronous active-low reset
//  P_DATA      in   DATA_WIDTH  byte to send, sampled when accepted
//  DATA_VALID  in   1           request to send P_DATA
//  PAR_EN      in   1           1 = insert parity bit, sampled on accept
//  PAR_TYP     in   1           0 = even, 1 = odd parity, sampled on accept
//  ser_DONE    in   1           serializer: last data bit is on ser_DATA this cycle
//  ser_DATA    in   1           serializer serial output
//  ser_EN      out  1           serializer enable
//  ser_P_DATA  out  DATA_WIDTH  latched byte driven to the serializer
//  TX_OUT      out  1           UART line, idle high
//  busy        out  1           frame in progress (state != IDLE)
//  ready       out  1           DATA_VALID will be accepted this cycle (IDLE or STOP)
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): state=IDLE, ser_P_DATA=0, latched PAR_EN/PAR_TYP=0.
//   Outputs after reset: TX_OUT=1, ser_EN=0, busy=0, ready=1. Reset wins over all inputs.
//  FSM (Moore outputs, registered state): IDLE, START, DATA, PARITY, STOP.
//   IDLE:   TX_OUT=1, ser_EN=0. DATA_VALID=1 -> latch P_DATA, PAR_EN, PAR_TYP; go START.
//   START:  TX_OUT=0, ser_EN=1 (serializer loads bit0 at this edge). Always go DATA.
//   DATA:   TX_OUT=ser_DATA, ser_EN=1.
//           ser_DONE=1 -> go PARITY if latched PAR_EN, else go STOP. Else stay in DATA.
//   PARITY: TX_OUT=^ser_P_DATA ^ PAR_TYP, ser_EN=0. Always go STOP.
//   STOP:   TX_OUT=1, ser_EN=0.
//           DATA_VALID=1 -> latch new data, go START (back-to-back, no idle gap). Else go IDLE.
//  Frame length: 1+DATA_WIDTH+PAR_EN+1 cycles (10 or 11 for 8 bits).
//  Accept latency: TX_OUT falls in the cycle after the accepting edge.
//  DATA_VALID is ignored in START/DATA/PARITY. Latched data and parity config stay stable for the whole frame.
//   Input changes mid-frame have no effect.
//  ser_DONE outside DATA is ignored. DATA is left only via ser_DONE; no internal bit count.
//  ser_EN drops in the cycle after ser_DONE, so the serializer counter returns to 0 before the next START.
//  TX_OUT is a combinational mux of state, ser_DATA and parity; all other state is registered.
//  Reset mid-frame: next cycle TX_OUT=1, ser_EN=0. The partial frame is abandoned and no stop bit is sent.
// TESTING (bench instantiates this block with uart_tx_serializer; sample TX_OUT each cycle)
//  Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, DATA_VALID 1 cycle.
//   -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 then idle 1; busy high 11 cycles.
//  Odd parity: P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> TX_OUT 0,0,0,0,0,0,0,0,0,1,1.
//  No parity: P_DATA=0xFF, PAR_EN=0 -> TX_OUT 0,1,1,1,1,1,1,1,1,1; busy high exactly 10 cycles.
//  Back-to-back: DATA_VALID held high with 0x01 then 0x80 presented on STOP.
//   -> stop bit 1 followed immediately by start bit 0; second frame data bits 0,0,0,0,0,0,0,1.
//  Mid-frame input change: P_DATA=0x3C accepted, then P_DATA=0xFF with DATA_VALID=1 during DATA.
//   -> frame still carries 0x3C; 0xFF not sent; ready=0 during START..PARITY.
//  Reset mid-frame: rst=0 for 1 cycle at the 4th data bit -> TX_OUT=1, busy=0, ser_EN=0 next cycle.
//   A following 0x55 frame is transmitted correctly.

Source files
------------

// File: rtl/uart_tx_frame_ctrl_if.sv
// Host-side handshake bundle for the UART transmit frame controller.
//   P_DATA      byte to send, sampled when accepted
//   DATA_VALID  request to send P_DATA
//   PAR_EN      1 = insert parity bit, sampled on accept
//   PAR_TYP     0 = even, 1 = odd parity, sampled on accept
//   busy        frame in progress
//   ready       DATA_VALID is accepted this cycle
interface uart_tx_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  busy;
  logic                  ready;

  // Host side: drives requests, observes status.
  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  busy, ready
  );

  // Frame controller side.
  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output busy, ready
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller. Latches a parallel byte from the host, then
// sequences start bit, data bits (shifted out by the downstream serializer),
// optional parity bit and stop bit onto TX_OUT, one bit per clk cycle.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   host        host handshake (P_DATA, DATA_VALID, PAR_EN, PAR_TYP, busy, ready)
//   ser_DONE    serializer: last data bit is on ser_DATA this cycle
//   ser_DATA    serializer serial output
//   ser_EN      serializer enable
//   ser_P_DATA  latched byte driven to the serializer
//   TX_OUT      UART line, idle high (combinational mux of state and data)
module uart_tx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8  // must match the serializer, max 15
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_frame_ctrl_if.slave   host,
  input  logic                  ser_DONE,
  input  logic                  ser_DATA,
  output logic                  ser_EN,
  output logic [DATA_WIDTH-1:0] ser_P_DATA,
  output logic                  TX_OUT
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  ser_en_q, ser_en_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  load;

  // Next-state, latch and registered-output decode.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    load      = 1'b0;

    unique case (state_q)
      IDLE:    load = host.DATA_VALID;
      START:   state_d = DATA;
      // DATA is left only on the serializer's done flag; no local bit count.
      DATA:    if (ser_DONE) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      // Accepting in STOP gives back-to-back frames with no idle gap.
      STOP:    begin
        load    = host.DATA_VALID;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d   = START;
      data_d    = host.P_DATA;
      par_en_d  = host.PAR_EN;
      par_typ_d = host.PAR_TYP;
    end

    // Decoded from next state so the registered outputs track state_q exactly.
    ser_en_d = (state_d == START) || (state_d == DATA);
    busy_d   = (state_d != IDLE);
    ready_d  = (state_d == IDLE) || (state_d == STOP);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      ser_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      ser_en_q  <= ser_en_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  // Line mux: data bits pass straight through from the serializer.
  always_comb begin
    TX_OUT = 1'b1;
    unique case (state_q)
      IDLE:    TX_OUT = 1'b1;
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = ser_DATA;
      PARITY:  TX_OUT = (^data_q) ^ par_typ_q;
      STOP:    TX_OUT = 1'b1;
      default: TX_OUT = 1'b1;
    endcase
  end

  assign ser_EN     = ser_en_q;
  assign ser_P_DATA = data_q;
  assign host.busy  = busy_q;
  assign host.ready = ready_q;

endmodule
